// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_bht
// Brief    : Execute-stage branch/jump resolution with a 2-bit counter BHT,
//            registered mispredict redirect and saturating statistics.
// Revision : 1.0
// ============================================================================
module branch_resolve_bht #(
    parameter int          XLEN        = 32,
    parameter int          BHT_ENTRIES = 64,
    parameter logic [1:0]  CNT_INIT    = 2'b01,
    parameter int          STAT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [XLEN-1:0]   i_f_pc,
    output logic              o_f_pred_taken,
    input  logic              i_ex_valid,
    input  logic              i_ex_jump,
    input  logic              i_ex_branch,
    input  logic [2:0]        i_ex_funct3,
    input  logic              i_ex_eq,
    input  logic              i_ex_slt,
    input  logic [XLEN-1:0]   i_ex_pc,
    input  logic [XLEN-1:0]   i_ex_target,
    input  logic              i_ex_pred_taken,
    output logic              o_ex_taken,
    output logic              o_flush,
    output logic [XLEN-1:0]   o_flush_pc,
    output logic [STAT_W-1:0] o_br_count,
    output logic [STAT_W-1:0] o_miss_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]        bht_q [BHT_ENTRIES];
    logic              flush_q;
    logic [XLEN-1:0]   flush_pc_q, flush_pc_d;
    logic [STAT_W-1:0] br_cnt_q, miss_cnt_q;

    logic [IDX_W-1:0]  w_f_idx, w_ex_idx;
    logic              w_cond, w_f3_ok, w_jump, w_br, w_taken, w_miss;
    logic [1:0]        w_ex_cnt, w_cnt_next;
    logic              w_unused_pc;

    assign w_f_idx        = i_f_pc[IDX_W+1:2];
    assign w_ex_idx       = i_ex_pc[IDX_W+1:2];
    assign o_f_pred_taken = bht_q[w_f_idx][1];
    // Only the index field of each PC matters to the table.
    assign w_unused_pc    = ^{i_f_pc, i_ex_pc};

    always_comb begin
        w_cond  = 1'b0;
        w_f3_ok = 1'b1;
        case (i_ex_funct3)
            3'b000:          w_cond = i_ex_eq;
            3'b001:          w_cond = ~i_ex_eq;
            3'b100, 3'b110:  w_cond = i_ex_slt;
            3'b101, 3'b111:  w_cond = ~i_ex_slt;
            default:         w_f3_ok = 1'b0;
        endcase
    end

    // Jump has priority if the caller ever raises both qualifiers.
    assign w_jump     = i_ex_valid & i_ex_jump;
    assign w_br       = i_ex_valid & ~i_ex_jump & i_ex_branch & w_f3_ok;
    assign w_taken    = w_jump | (w_br & w_cond);
    assign w_miss     = (w_jump | w_br) & (w_taken != i_ex_pred_taken);
    assign o_ex_taken = w_taken;

    assign w_ex_cnt   = bht_q[w_ex_idx];
    always_comb begin
        w_cnt_next = w_ex_cnt;
        if (w_taken) begin
            if (w_ex_cnt != 2'b11) w_cnt_next = w_ex_cnt + 2'b01;
        end else begin
            if (w_ex_cnt != 2'b00) w_cnt_next = w_ex_cnt - 2'b01;
        end
    end

    always_comb begin
        flush_pc_d = flush_pc_q;
        if (w_miss) flush_pc_d = w_taken ? i_ex_target : (i_ex_pc + XLEN'(4));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_INIT;
        end else if (w_br) begin
            bht_q[w_ex_idx] <= w_cnt_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            flush_q    <= w_miss;
            flush_pc_q <= flush_pc_d;
            if (w_br && !(&br_cnt_q))     br_cnt_q   <= br_cnt_q + STAT_W'(1);
            if (w_miss && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + STAT_W'(1);
        end
    end

    assign o_flush      = flush_q;
    assign o_flush_pc   = flush_pc_q;
    assign o_br_count   = br_cnt_q;
    assign o_miss_count = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_bht
// Brief    : Directed self-checking bench; a STAT_W=4 twin checks saturation.
// Revision : 1.0
// ============================================================================
module tb_branch_resolve_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        ex_valid, ex_jump, ex_branch, ex_eq, ex_slt, ex_pred;
    logic [2:0]  ex_f3;
    logic [31:0] ex_pc, ex_target;

    logic        pred_a, taken_a, flush_a;
    logic [31:0] fpc_a;
    logic [15:0] br_a, miss_a;
    logic        pred_b, taken_b, flush_b;
    logic [31:0] fpc_b;
    logic [3:0]  br_b, miss_b;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    branch_resolve_bht u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_f_pc(f_pc), .o_f_pred_taken(pred_a),
        .i_ex_valid(ex_valid), .i_ex_jump(ex_jump), .i_ex_branch(ex_branch),
        .i_ex_funct3(ex_f3), .i_ex_eq(ex_eq), .i_ex_slt(ex_slt),
        .i_ex_pc(ex_pc), .i_ex_target(ex_target), .i_ex_pred_taken(ex_pred),
        .o_ex_taken(taken_a), .o_flush(flush_a), .o_flush_pc(fpc_a),
        .o_br_count(br_a), .o_miss_count(miss_a)
    );

    branch_resolve_bht #(.STAT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_f_pc(f_pc), .o_f_pred_taken(pred_b),
        .i_ex_valid(ex_valid), .i_ex_jump(ex_jump), .i_ex_branch(ex_branch),
        .i_ex_funct3(ex_f3), .i_ex_eq(ex_eq), .i_ex_slt(ex_slt),
        .i_ex_pc(ex_pc), .i_ex_target(ex_target), .i_ex_pred_taken(ex_pred),
        .o_ex_taken(taken_b), .o_flush(flush_b), .o_flush_pc(fpc_b),
        .o_br_count(br_b), .o_miss_count(miss_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic j, input logic b, input logic [2:0] f3,
                         input logic eq, input logic slt, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pr);
        ex_valid = v; ex_jump = j; ex_branch = b; ex_f3 = f3;
        ex_eq = eq; ex_slt = slt; ex_pc = pc; ex_target = tgt; ex_pred = pr;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        f_pc  = 32'h100;
        drive(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check_eq("rst_pred",  {31'b0, pred_a}, 32'd0);
        check_eq("rst_flush", {31'b0, flush_a}, 32'd0);
        check_eq("rst_fpc",   fpc_a, 32'h0);
        check_eq("rst_br",    {16'b0, br_a}, 32'd0);
        check_eq("rst_miss",  {16'b0, miss_a}, 32'd0);

        // Four BEQ taken at 0x100 with predict-not-taken: 01->10->11->11->11
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 3'b000, 1, 0, 32'h100, 32'h180, 0);
            check_eq("beq_taken", {31'b0, taken_a}, 32'd1);
            if (k == 0) check_eq("beq_pred_pre", {31'b0, pred_a}, 32'd0);
            tick();
            check_eq("beq_flush", {31'b0, flush_a}, 32'd1);
            check_eq("beq_fpc",   fpc_a, 32'h180);
            check_eq("beq_pred",  {31'b0, pred_a}, 32'd1);
        end
        check_eq("beq_br",   {16'b0, br_a}, 32'd4);
        check_eq("beq_miss", {16'b0, miss_a}, 32'd4);

        drive(0, 1, 1, 3'b000, 1, 0, 32'h100, 32'h999, 0);
        check_eq("idle_taken", {31'b0, taken_a}, 32'd0);
        tick();
        check_eq("idle_flush", {31'b0, flush_a}, 32'd0);
        check_eq("idle_fpc",   fpc_a, 32'h180);
        check_eq("idle_miss",  {16'b0, miss_a}, 32'd4);

        // BLT not taken at 0x200 (aliases entry 0): 11->10
        drive(1, 0, 1, 3'b100, 0, 0, 32'h200, 32'h240, 1);
        check_eq("blt_taken", {31'b0, taken_a}, 32'd0);
        tick();
        check_eq("blt_flush", {31'b0, flush_a}, 32'd1);
        check_eq("blt_fpc",   fpc_a, 32'h204);
        check_eq("blt_miss",  {16'b0, miss_a}, 32'd5);
        check_eq("blt_pred",  {31'b0, pred_a}, 32'd1);

        // BGE eq=1 slt=0 at 0x304 (entry 1), correctly predicted taken
        f_pc = 32'h304;
        drive(1, 0, 1, 3'b101, 1, 0, 32'h304, 32'h400, 1);
        check_eq("bge_taken", {31'b0, taken_a}, 32'd1);
        tick();
        check_eq("bge_flush", {31'b0, flush_a}, 32'd0);
        check_eq("bge_br",    {16'b0, br_a}, 32'd6);
        check_eq("bge_miss",  {16'b0, miss_a}, 32'd5);
        check_eq("bge_pred",  {31'b0, pred_a}, 32'd1);

        // JAL at 0x308 (entry 2) predicted not taken: flush, no table/branch change
        f_pc = 32'h308;
        drive(1, 1, 0, 3'b010, 0, 0, 32'h308, 32'h1000, 0);
        check_eq("jal_taken", {31'b0, taken_a}, 32'd1);
        tick();
        check_eq("jal_flush", {31'b0, flush_a}, 32'd1);
        check_eq("jal_fpc",   fpc_a, 32'h1000);
        check_eq("jal_br",    {16'b0, br_a}, 32'd6);
        check_eq("jal_miss",  {16'b0, miss_a}, 32'd6);
        check_eq("jal_pred",  {31'b0, pred_a}, 32'd0);

        // funct3=010 branch is ignored entirely
        drive(1, 0, 1, 3'b010, 1, 1, 32'h308, 32'h2000, 1);
        check_eq("inv_taken", {31'b0, taken_a}, 32'd0);
        tick();
        check_eq("inv_flush", {31'b0, flush_a}, 32'd0);
        check_eq("inv_fpc",   fpc_a, 32'h1000);
        check_eq("inv_br",    {16'b0, br_a}, 32'd6);
        check_eq("inv_miss",  {16'b0, miss_a}, 32'd6);
        check_eq("inv_pred",  {31'b0, pred_a}, 32'd0);

        // BNE not taken at top of address space: redirect wraps to 0
        drive(1, 0, 1, 3'b001, 1, 0, 32'hFFFF_FFFC, 32'h10, 1);
        tick();
        check_eq("wrap_flush", {31'b0, flush_a}, 32'd1);
        check_eq("wrap_fpc",   fpc_a, 32'h0);

        // Same-cycle lookup 0x100 / update 0x200 of entry 0 (10 -> 01)
        f_pc = 32'h100;
        drive(1, 0, 1, 3'b000, 0, 0, 32'h200, 32'h300, 1);
        check_eq("alias_pre",  {31'b0, pred_a}, 32'd1);
        tick();
        check_eq("alias_post", {31'b0, pred_a}, 32'd0);
        check_eq("alias_fpc",  fpc_a, 32'h204);
        check_eq("alias_br",   {16'b0, br_a}, 32'd8);
        check_eq("alias_miss", {16'b0, miss_a}, 32'd8);
        check_eq("alias_br4",  {28'b0, br_b}, 32'd8);

        // 20 more mispredicts: narrow counter saturates at 15
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 0, 3'b000, 0, 0, 32'h400, 32'h500, 0);
            tick();
        end
        check_eq("sat_miss4", {28'b0, miss_b}, 32'd15);
        check_eq("sat_miss",  {16'b0, miss_a}, 32'd28);
        check_eq("sat_br4",   {28'b0, br_b}, 32'd8);
        check_eq("sat_flush", {31'b0, flush_a}, 32'd1);

        // Asynchronous reset while a flush is showing
        f_pc = 32'h304;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_flush", {31'b0, flush_a}, 32'd0);
        check_eq("arst_fpc",   fpc_a, 32'h0);
        check_eq("arst_br",    {16'b0, br_a}, 32'd0);
        check_eq("arst_miss",  {16'b0, miss_a}, 32'd0);
        check_eq("arst_miss4", {28'b0, miss_b}, 32'd0);
        check_eq("arst_pred",  {31'b0, pred_a}, 32'd0);
        drive(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_flush", {31'b0, flush_a}, 32'd0);
        check_eq("post_miss",  {16'b0, miss_a}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
